clock_time_counter: RTL and testbench

- Consumes the divided square wave (1 Hz at 50 MHz clk_in) from the clock divider stage.
- Runs entirely in the clk_in domain. The slow wave is synchronised, rising-edge detected and turned into a one-cycle tick that advances a BCD HH:MM:SS time-of-day counter (24 h).
- Provides a set mode for adjusting minutes and hours.
- Digit outputs feed the seven-segment display driver downstream.

---
 rtl/clock_time_counter.sv | 164 ++++++++++++++++
 tb/tb_clock_time_counter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// BCD HH:MM:SS time-of-day counter (24 h) advanced by a synchronised slow tick,
// with a set mode for adjusting minutes and hours.
module clock_time_counter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       slow_clk_in,
  input  logic       run,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       clr_sec,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [1:0] hr_tens,
  output logic       tick_out,
  output logic       day_wrap
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  logic                   inc_min_q, inc_hour_q;
  logic                   set_q;
  logic [3:0]             sec_ones_q, sec_ones_d;
  logic [2:0]             sec_tens_q, sec_tens_d;
  logic [3:0]             min_ones_q, min_ones_d;
  logic [2:0]             min_tens_q, min_tens_d;
  logic [3:0]             hr_ones_q, hr_ones_d;
  logic [1:0]             hr_tens_q, hr_tens_d;
  logic                   tick_out_q, day_wrap_q, day_wrap_d;

  logic                   tick_det;
  logic                   min_rise, hour_rise;
  logic [3:0]             min_ones_inc, hr_ones_inc;
  logic [2:0]             min_tens_inc;
  logic [1:0]             hr_tens_inc;
  logic                   min_wrap, hr_wrap;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], slow_clk_in};
  assign tick_det  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign min_rise  = inc_min & ~inc_min_q;
  assign hour_rise = inc_hour & ~inc_hour_q;

  // Minutes +1 with wrap flag (caller decides whether the wrap carries)
  always_comb begin
    min_ones_inc = min_ones_q + 4'd1;
    min_tens_inc = min_tens_q;
    min_wrap     = 1'b0;
    if (min_ones_q == 4'd9) begin
      min_ones_inc = 4'd0;
      if (min_tens_q == 3'd5) begin
        min_tens_inc = 3'd0;
        min_wrap     = 1'b1;
      end else begin
        min_tens_inc = min_tens_q + 3'd1;
      end
    end
  end

  // Hours +1 over 00..23 with wrap flag
  always_comb begin
    hr_ones_inc = hr_ones_q + 4'd1;
    hr_tens_inc = hr_tens_q;
    hr_wrap     = 1'b0;
    if (hr_tens_q == 2'd2 && hr_ones_q == 4'd3) begin
      hr_ones_inc = 4'd0;
      hr_tens_inc = 2'd0;
      hr_wrap     = 1'b1;
    end else if (hr_ones_q == 4'd9) begin
      hr_ones_inc = 4'd0;
      hr_tens_inc = hr_tens_q + 2'd1;
    end
  end

  // Next time: set-mode adjustments, or a counting tick with full carry chain
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    hr_ones_d  = hr_ones_q;
    hr_tens_d  = hr_tens_q;
    day_wrap_d = 1'b0;
    if (set_q) begin
      if (clr_sec) begin
        sec_ones_d = 4'd0;
        sec_tens_d = 3'd0;
      end
      if (min_rise) begin
        min_ones_d = min_ones_inc;
        min_tens_d = min_tens_inc;
      end
      if (hour_rise) begin
        hr_ones_d = hr_ones_inc;
        hr_tens_d = hr_tens_inc;
      end
    end else if (tick_det && run) begin
      if (sec_ones_q != 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q != 3'd5) begin
          sec_tens_d = sec_tens_q + 3'd1;
        end else begin
          sec_tens_d = 3'd0;
          min_ones_d = min_ones_inc;
          min_tens_d = min_tens_inc;
          if (min_wrap) begin
            hr_ones_d  = hr_ones_inc;
            hr_tens_d  = hr_tens_inc;
            day_wrap_d = hr_wrap;
          end
        end
      end
    end
  end

  // State registers; history flops reset high so no edge is seen out of reset
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q     <= '1;
      prev_q     <= 1'b1;
      inc_min_q  <= 1'b1;
      inc_hour_q <= 1'b1;
      set_q      <= 1'b0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 3'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 3'd0;
      hr_ones_q  <= 4'd0;
      hr_tens_q  <= 2'd0;
      tick_out_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= sync_q[SYNC_STAGES-1];
      inc_min_q  <= inc_min;
      inc_hour_q <= inc_hour;
      set_q      <= set_mode;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      hr_ones_q  <= hr_ones_d;
      hr_tens_q  <= hr_tens_d;
      tick_out_q <= tick_det;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign hr_ones  = hr_ones_q;
  assign hr_tens  = hr_tens_q;
  assign tick_out = tick_out_q;
  assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter: tick latency, counting, set mode,
// hold and asynchronous reset.
module tb_clock_time_counter;

  localparam int unsigned SS = 2;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       slow_clk_in = 1'b1;
  logic       run = 1'b1;
  logic       set_mode = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic       clr_sec = 1'b0;
  logic [3:0] sec_ones, min_ones, hr_ones;
  logic [2:0] sec_tens, min_tens;
  logic [1:0] hr_tens;
  logic       tick_out, day_wrap;

  int checks = 0;
  int errors = 0;
  int tick_pulses = 0;
  int tick_hi = 0;
  int dw_cnt = 0;
  int dw_bad = 0;
  int swrap = 0;
  int prev_sec = 0;
  logic tick_prev = 1'b0;

  clock_time_counter #(.SYNC_STAGES(SS)) dut (
    .clk_in(clk_in), .rst(rst), .slow_clk_in(slow_clk_in), .run(run),
    .set_mode(set_mode), .inc_min(inc_min), .inc_hour(inc_hour),
    .clr_sec(clr_sec), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .hr_ones(hr_ones),
    .hr_tens(hr_tens), .tick_out(tick_out), .day_wrap(day_wrap)
  );

  always #10 clk_in = ~clk_in;

  function automatic int cur_time();
    return int'(hr_tens) * 100000 + int'(hr_ones) * 10000 +
           int'(min_tens) * 1000 + int'(min_ones) * 100 +
           int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  // Pulse statistics sampled away from the active edge
  always @(negedge clk_in) begin
    if (tick_out) tick_hi++;
    if (tick_out && !tick_prev) tick_pulses++;
    tick_prev = tick_out;
    if (day_wrap) dw_cnt++;
    if (day_wrap && !tick_out) dw_bad++;
    if (prev_sec == 59 && (int'(sec_tens) * 10 + int'(sec_ones)) == 0) swrap++;
    prev_sec = int'(sec_tens) * 10 + int'(sec_ones);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick(input bit lat);
    slow_clk_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (lat) begin
        if (i == int'(SS) - 1) check("lat_pre", int'(tick_out), 0);
        if (i == int'(SS))     check("lat_hit", int'(tick_out), 1);
        if (i == int'(SS) + 1) check("lat_post", int'(tick_out), 0);
      end
    end
    slow_clk_in = 1'b0;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      inc_min = 1'b1;
      repeat (2) @(negedge clk_in);
      inc_min = 1'b0;
      repeat (2) @(negedge clk_in);
    end
  endtask

  task automatic pulse_hour(input int n);
    for (int i = 0; i < n; i++) begin
      inc_hour = 1'b1;
      repeat (2) @(negedge clk_in);
      inc_hour = 1'b0;
      repeat (2) @(negedge clk_in);
    end
  endtask

  task automatic clear_stats();
    tick_pulses = 0;
    tick_hi = 0;
    dw_cnt = 0;
    dw_bad = 0;
    swrap = 0;
  endtask

  task automatic enter_set(input logic v);
    set_mode = v;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic short_reset();
    @(negedge clk_in);
    rst = 1'b1;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    // Reset held with slow wave high, then released: no spurious tick
    repeat (50) @(negedge clk_in);
    check("rst_time", cur_time(), 0);
    check("rst_tick", int'(tick_out), 0);
    rst = 1'b0;
    clear_stats();
    repeat (20) @(negedge clk_in);
    check("post_rst_ticks", tick_pulses, 0);
    check("post_rst_time", cur_time(), 0);
    check("post_rst_dw", dw_cnt, 0);
    slow_clk_in = 1'b0;
    repeat (10) @(negedge clk_in);

    // 60 rising edges: latency on the first, single-cycle pulses, one sec wrap
    clear_stats();
    do_tick(1'b1);
    ticks(59);
    check("cnt_time", cur_time(), 100);
    check("cnt_pulses", tick_pulses, 60);
    check("cnt_hi", tick_hi, 60);
    check("cnt_swrap", swrap, 1);

    // Set to 23:59:xx, clear seconds, then count through the day boundary
    short_reset();
    ticks(5);
    check("pre_set", cur_time(), 5);
    enter_set(1'b1);
    clear_stats();
    do_tick(1'b0);
    check("set_tick_hold", cur_time(), 5);
    check("set_tick_pulse", tick_pulses, 1);
    pulse_hour(23);
    pulse_min(59);
    check("set_2359", cur_time(), 235905);
    clr_sec = 1'b1;
    repeat (2) @(negedge clk_in);
    clr_sec = 1'b0;
    repeat (2) @(negedge clk_in);
    check("clr_sec", cur_time(), 235900);
    enter_set(1'b0);
    ticks(59);
    check("to_235959", cur_time(), 235959);
    clear_stats();
    do_tick(1'b0);
    check("day_rollover", cur_time(), 0);
    check("day_wrap_cnt", dw_cnt, 1);
    check("day_wrap_coinc", dw_bad, 0);

    // Set-mode increments: wraps without carry, held level, simultaneous edges
    enter_set(1'b1);
    clear_stats();
    pulse_min(61);
    check("min61", cur_time(), 100);
    inc_hour = 1'b1;
    repeat (100) @(negedge clk_in);
    inc_hour = 1'b0;
    repeat (2) @(negedge clk_in);
    check("hour_held", cur_time(), 10100);
    inc_min = 1'b1;
    inc_hour = 1'b1;
    repeat (2) @(negedge clk_in);
    inc_min = 1'b0;
    inc_hour = 1'b0;
    repeat (2) @(negedge clk_in);
    check("both_inc", cur_time(), 20200);
    pulse_hour(22);
    check("hour_wrap", cur_time(), 200);
    check("hour_wrap_dw", dw_cnt, 0);
    // Edge seen outside set mode is not replayed on entering it
    enter_set(1'b0);
    inc_min = 1'b1;
    repeat (2) @(negedge clk_in);
    enter_set(1'b1);
    inc_min = 1'b0;
    repeat (2) @(negedge clk_in);
    check("no_replay", cur_time(), 200);

    // Hold with run=0, then resume
    enter_set(1'b0);
    run = 1'b0;
    clear_stats();
    ticks(5);
    check("hold_time", cur_time(), 200);
    check("hold_pulses", tick_pulses, 5);
    run = 1'b1;
    do_tick(1'b0);
    check("resume", cur_time(), 201);

    // Reach 12:34:56, then asynchronous reset between clock edges
    enter_set(1'b1);
    pulse_hour(12);
    pulse_min(32);
    clr_sec = 1'b1;
    repeat (2) @(negedge clk_in);
    clr_sec = 1'b0;
    enter_set(1'b0);
    ticks(56);
    check("at_123456", cur_time(), 123456);
    slow_clk_in = 1'b1;
    @(negedge clk_in);
    #3 rst = 1'b1;
    #1;
    check("async_rst_time", cur_time(), 0);
    check("async_rst_tick", int'(tick_out), 0);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    clear_stats();
    repeat (20) @(negedge clk_in);
    check("rst_hi_ticks", tick_pulses, 0);
    check("rst_hi_time", cur_time(), 0);
    slow_clk_in = 1'b0;
    repeat (10) @(negedge clk_in);
    do_tick(1'b1);
    check("restart_time", cur_time(), 1);
    check("restart_pulses", tick_pulses, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
